// File: rtl/vga_text_pkg.sv
// Shared constants, pixel tag type and character mapping for the time/score text overlay.
package vga_text_pkg;

  localparam logic [6:0] CH_DIGIT0 = 7'h30;
  localparam logic [6:0] CH_COLON  = 7'h3a;
  localparam logic [6:0] CH_BLANK  = 7'h00;
  localparam logic [6:0] CH_BAD    = 7'h3f;
  localparam int         FONT_W    = 8;
  localparam int         FONT_H    = 16;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } colon_phase_e;

  // Per-pixel info that must stay aligned with the font ROM read.
  typedef struct packed {
    logic       on;
    logic [2:0] bit_idx;
  } pix_tag_t;

  function automatic logic [6:0] char_code(input logic [3:0] digit,
                                           input logic       is_colon,
                                           input logic       colon_vis);
    if (is_colon) begin
      return colon_vis ? CH_COLON : CH_BLANK;
    end else if (digit <= 4'd9) begin
      return CH_DIGIT0 + {3'b000, digit};
    end else begin
      return CH_BAD;
    end
  endfunction

endpackage

// File: rtl/vga_text_blink.sv
// Colon blink generator: counts frame ticks and toggles the colon phase every BLINK_FRAMES frames.
module vga_text_blink
  import vga_text_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic blink_en,
  output logic colon_vis
);

  localparam int             CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  colon_phase_e  phase_q, phase_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= PH_VISIBLE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Disabling blink parks the counter so re-enabling always gives a full first half-period.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      cnt_d   = '0;
      phase_d = PH_VISIBLE;
    end else if (frame_tick) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign colon_vis = (phase_q == PH_VISIBLE);

endmodule

// File: rtl/vga_time_text.sv
// Renders N_DIGITS shadowed BCD digits as colon-separated pairs, pipelined around the font ROM.
module vga_time_text
  import vga_text_pkg::*;
#(
  parameter int         N_DIGITS     = 4,
  parameter int         SCALE_LOG2   = 1,
  parameter int         ROW_Y        = 7,
  parameter int         COL_X        = 2,
  parameter logic [2:0] FG_RGB       = 3'b001,
  parameter logic [2:0] BG_RGB       = 3'b110,
  parameter int         BLINK_FRAMES = 30,
  parameter int         ROM_LAT      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic                  blink_en,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  output logic [10:0]           rom_addr,
  input  logic [7:0]            font_word,
  output logic                  text_on,
  output logic [2:0]            text_rgb
);

  localparam int NCHARS = N_DIGITS + N_DIGITS / 2 - 1;
  localparam int SHX    = $clog2(FONT_W) + SCALE_LOG2;
  localparam int SHY    = $clog2(FONT_H) + SCALE_LOG2;

  logic [4*N_DIGITS-1:0] shadow_q;
  logic                  colon_vis;

  logic [10:0] cell_x, cell_y, ci;
  logic [3:0]  ci_s, k, dig;
  logic [1:0]  pos;
  logic        in_region;
  logic [6:0]  code;
  logic [10:0] rom_addr_d, rom_addr_q;
  pix_tag_t    tag_d, tag_b;
  pix_tag_t    tag_q [0:ROM_LAT];
  logic        text_on_d, text_on_q;
  logic [2:0]  text_rgb_d, text_rgb_q;

  vga_text_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .blink_en  (blink_en),
    .colon_vis (colon_vis)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
    end else if (frame_tick) begin
      shadow_q <= digits;
    end
  end

  // Stage A: ci is unsigned, so pixels left of COL_X wrap high and fall outside the region.
  always_comb begin
    cell_x    = {1'b0, pix_x} >> SHX;
    cell_y    = {1'b0, pix_y} >> SHY;
    ci        = cell_x - 11'(COL_X);
    in_region = (cell_y == 11'(ROW_Y)) && (ci < 11'(NCHARS));
    ci_s      = ci[3:0];
    pos       = 2'(ci_s % 4'd3);
    k         = 4'(ci_s / 4'd3) * 4'd2 + {2'b00, pos};
    dig       = 4'(shadow_q >> {k, 2'b00});
    code      = in_region ? char_code(dig, pos == 2'd2, colon_vis) : CH_BLANK;
    rom_addr_d    = {code, 4'(pix_y >> SCALE_LOG2)};
    tag_d.on      = in_region;
    tag_d.bit_idx = 3'(pix_x >> SCALE_LOG2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
      text_on_q  <= 1'b0;
      text_rgb_q <= BG_RGB;
    end else begin
      rom_addr_q <= rom_addr_d;
      tag_q[0]   <= tag_d;
      for (int i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      text_on_q  <= text_on_d;
      text_rgb_q <= text_rgb_d;
    end
  end

  // Stage B: the tag arrives together with the font word for the same pixel.
  always_comb begin
    tag_b      = tag_q[ROM_LAT];
    text_on_d  = tag_b.on;
    text_rgb_d = BG_RGB;
    if (tag_b.on && font_word[3'd7 - tag_b.bit_idx]) text_rgb_d = FG_RGB;
  end

  assign rom_addr = rom_addr_q;
  assign text_on  = text_on_q;
  assign text_rgb = text_rgb_q;

endmodule

// File: tb/tb_vga_time_text.sv
// Directed bench for vga_time_text: a 4-digit instance (ROM_LAT=1) and a 6-digit instance (ROM_LAT=2).
module tb_vga_time_text;

  localparam logic [2:0] FG = 3'b001;
  localparam logic [2:0] BG = 3'b110;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        blink_en = 1'b0;
  logic [15:0] digits = '0;
  logic [23:0] digits6 = '0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [10:0] rom_addr1, rom_addr2;
  logic [7:0]  font1 = '0;
  logic [7:0]  font2;
  logic        on1, on2;
  logic [2:0]  rgb1, rgb2;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[10:3] ^ 8'ha5;
  endfunction

  // Registered font ROM model for the ROM_LAT=1 instance; constant left-column font for the other.
  always @(posedge clk) font1 <= rom_fn(rom_addr1);
  assign font2 = 8'b1000_0000;

  vga_time_text #(
    .N_DIGITS(4), .SCALE_LOG2(1), .ROW_Y(7), .COL_X(4), .FG_RGB(FG), .BG_RGB(BG),
    .BLINK_FRAMES(2), .ROM_LAT(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .digits(digits),
    .blink_en(blink_en), .pix_x(pix_x), .pix_y(pix_y), .rom_addr(rom_addr1),
    .font_word(font1), .text_on(on1), .text_rgb(rgb1)
  );

  vga_time_text #(
    .N_DIGITS(6), .SCALE_LOG2(1), .ROW_Y(7), .COL_X(2), .FG_RGB(FG), .BG_RGB(BG),
    .BLINK_FRAMES(2), .ROM_LAT(2)
  ) u_dut6 (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .digits(digits6),
    .blink_en(blink_en), .pix_x(pix_x), .pix_y(pix_y), .rom_addr(rom_addr2),
    .font_word(font2), .text_on(on2), .text_rgb(rgb2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
    tick();
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (rom_addr1 !== 11'h000) begin failures++; $display("FAIL reset_rom_addr got=%h exp=%h", rom_addr1, 11'h000); end
    checks++; if (on1 !== 1'b0) begin failures++; $display("FAIL reset_text_on got=%b exp=0", on1); end
    checks++; if (rgb1 !== BG) begin failures++; $display("FAIL reset_text_rgb got=%b exp=%b", rgb1, BG); end
    checks++; if (rom_addr2 !== 11'h000) begin failures++; $display("FAIL reset_rom_addr6 got=%h exp=%h", rom_addr2, 11'h000); end
    checks++; if (rgb2 !== BG) begin failures++; $display("FAIL reset_text_rgb6 got=%b exp=%b", rgb2, BG); end
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  // "12:34" on row 224: cells at x=64,80,96,112,128; text is 2 cycles behind rom_addr.
  task automatic test_chars();
    logic [6:0]  c1 [5] = '{7'h31, 7'h32, 7'h3a, 7'h33, 7'h34};
    logic [10:0] ea;
    logic [7:0]  fw;
    logic [2:0]  er;
    logic        ein;
    int          x, xp, b;
    digits  = 16'h4321;
    digits6 = 24'h654321;
    pulse_frame();
    for (int i = 0; i < 95; i++) begin
      x = 58 + i;
      drive_pix(x, 224);
      ein = (x >= 64) && (x < 144);
      ea  = ein ? {c1[(x - 64) / 16], 4'h0} : 11'h000;
      checks++; if (rom_addr1 !== ea) begin failures++; $display("FAIL chars_rom_addr x=%0d got=%h exp=%h", x, rom_addr1, ea); end
      if (i >= 2) begin
        xp  = x - 2;
        ein = (xp >= 64) && (xp < 144);
        ea  = ein ? {c1[(xp - 64) / 16], 4'h0} : 11'h000;
        fw  = rom_fn(ea);
        b   = (xp >> 1) & 7;
        er  = (ein && fw[7 - b]) ? FG : BG;
        checks++; if (on1 !== ein) begin failures++; $display("FAIL chars_text_on x=%0d got=%b exp=%b", xp, on1, ein); end
        checks++; if (rgb1 !== er) begin failures++; $display("FAIL chars_text_rgb x=%0d got=%b exp=%b", xp, rgb1, er); end
      end
    end
    drive_pix(80, 223);
    checks++; if (rom_addr1 !== 11'h00f) begin failures++; $display("FAIL row_above_rom_addr got=%h exp=%h", rom_addr1, 11'h00f); end
    drive_pix(80, 256);
    checks++; if (rom_addr1 !== 11'h000) begin failures++; $display("FAIL row_below_rom_addr got=%h exp=%h", rom_addr1, 11'h000); end
    tick();
    checks++; if (on1 !== 1'b0) begin failures++; $display("FAIL row_above_text_on got=%b exp=0", on1); end
  endtask

  task automatic test_shadow();
    logic [6:0] old_c [4] = '{7'h31, 7'h32, 7'h33, 7'h34};
    logic [6:0] new_c [4] = '{7'h35, 7'h36, 7'h37, 7'h38};
    int         xs    [4] = '{64, 80, 112, 128};
    digits = 16'h8765;
    for (int i = 0; i < 4; i++) begin
      drive_pix(xs[i], 224);
      checks++; if (rom_addr1 !== {old_c[i], 4'h0}) begin failures++; $display("FAIL shadow_hold x=%0d got=%h exp=%h", xs[i], rom_addr1, {old_c[i], 4'h0}); end
    end
    pulse_frame();
    for (int i = 0; i < 4; i++) begin
      drive_pix(xs[i], 224);
      checks++; if (rom_addr1 !== {new_c[i], 4'h0}) begin failures++; $display("FAIL shadow_update x=%0d got=%h exp=%h", xs[i], rom_addr1, {new_c[i], 4'h0}); end
    end
  endtask

  task automatic test_bad_digit();
    digits = 16'hf0b0;
    pulse_frame();
    drive_pix(64, 224);
    checks++; if (rom_addr1 !== 11'h300) begin failures++; $display("FAIL bad_d0 got=%h exp=%h", rom_addr1, 11'h300); end
    drive_pix(80, 224);
    checks++; if (rom_addr1 !== 11'h3f0) begin failures++; $display("FAIL bad_d1 got=%h exp=%h", rom_addr1, 11'h3f0); end
    drive_pix(128, 224);
    checks++; if (rom_addr1 !== 11'h3f0) begin failures++; $display("FAIL bad_d3 got=%h exp=%h", rom_addr1, 11'h3f0); end
    digits = 16'ha9a9;
    pulse_frame();
    drive_pix(64, 224);
    checks++; if (rom_addr1 !== 11'h390) begin failures++; $display("FAIL nine_d0 got=%h exp=%h", rom_addr1, 11'h390); end
    drive_pix(80, 224);
    checks++; if (rom_addr1 !== 11'h3f0) begin failures++; $display("FAIL ten_d1 got=%h exp=%h", rom_addr1, 11'h3f0); end
  endtask

  // With BLINK_FRAMES=2 the colon is visible for frames 0-1, hidden 2-3, visible 4-5.
  task automatic test_blink();
    logic [10:0] ea;
    blink_en = 1'b1;
    tick();
    for (int f = 0; f < 6; f++) begin
      drive_pix(96, 224);
      ea = (((f / 2) % 2) == 0) ? 11'h3a0 : 11'h000;
      checks++; if (rom_addr1 !== ea) begin failures++; $display("FAIL blink_frame%0d got=%h exp=%h", f, rom_addr1, ea); end
      pulse_frame();
    end
    blink_en = 1'b0;
    tick();
    for (int f = 0; f < 3; f++) begin
      drive_pix(96, 224);
      checks++; if (rom_addr1 !== 11'h3a0) begin failures++; $display("FAIL steady_frame%0d got=%h exp=%h", f, rom_addr1, 11'h3a0); end
      pulse_frame();
    end
  endtask

  // "12:34:56" from x=32 to 159; font 8'h80 lights only the first 2 pixels of each cell.
  task automatic test_six();
    logic [6:0]  c2 [8] = '{7'h31, 7'h32, 7'h3a, 7'h33, 7'h34, 7'h3a, 7'h35, 7'h36};
    logic [10:0] ea;
    logic [2:0]  er;
    logic        ein;
    int          x, xp;
    for (int i = 0; i < 140; i++) begin
      x = 26 + i;
      drive_pix(x, 224);
      ein = (x >= 32) && (x < 160);
      ea  = ein ? {c2[(x - 32) / 16], 4'h0} : 11'h000;
      checks++; if (rom_addr2 !== ea) begin failures++; $display("FAIL six_rom_addr x=%0d got=%h exp=%h", x, rom_addr2, ea); end
      if (i >= 3) begin
        xp  = x - 3;
        ein = (xp >= 32) && (xp < 160);
        er  = (ein && ((xp % 16) < 2)) ? FG : BG;
        checks++; if (on2 !== ein) begin failures++; $display("FAIL six_text_on x=%0d got=%b exp=%b", xp, on2, ein); end
        checks++; if (rgb2 !== er) begin failures++; $display("FAIL six_text_rgb x=%0d got=%b exp=%b", xp, rgb2, er); end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_pix(64, 224);
    tick();
    tick();
    checks++; if (on1 !== 1'b1) begin failures++; $display("FAIL pre_reset_text_on got=%b exp=1", on1); end
    reset_n = 1'b0;
    #1;
    checks++; if (on1 !== 1'b0) begin failures++; $display("FAIL async_text_on got=%b exp=0", on1); end
    checks++; if (rgb1 !== BG) begin failures++; $display("FAIL async_text_rgb got=%b exp=%b", rgb1, BG); end
    checks++; if (rom_addr1 !== 11'h000) begin failures++; $display("FAIL async_rom_addr got=%h exp=%h", rom_addr1, 11'h000); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (rom_addr1 !== 11'h300) begin failures++; $display("FAIL post_reset_rom_addr got=%h exp=%h", rom_addr1, 11'h300); end
    checks++; if (on1 !== 1'b0) begin failures++; $display("FAIL post_reset_c1_text_on got=%b exp=0", on1); end
    tick();
    checks++; if (on1 !== 1'b0) begin failures++; $display("FAIL post_reset_c2_text_on got=%b exp=0", on1); end
    tick();
    checks++; if (on1 !== 1'b1) begin failures++; $display("FAIL post_reset_c3_text_on got=%b exp=1", on1); end
    checks++; if (rgb1 !== FG) begin failures++; $display("FAIL post_reset_c3_text_rgb got=%b exp=%b", rgb1, FG); end
    drive_pix(96, 224);
    checks++; if (rom_addr1 !== 11'h3a0) begin failures++; $display("FAIL post_reset_colon got=%h exp=%h", rom_addr1, 11'h3a0); end
    drive_pix(128, 224);
    checks++; if (rom_addr1 !== 11'h300) begin failures++; $display("FAIL post_reset_d3 got=%h exp=%h", rom_addr1, 11'h300); end
  endtask

  initial begin
    test_reset();
    test_chars();
    test_shadow();
    test_bad_digit();
    test_blink();
    test_six();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
